mult_div_unit: RTL and testbench
================================

# mult_div_unit

Sequential multiply/divide unit for the multicycle MIPS datapath. It sits beside the ALU stage, takes the A/B register contents and an operation code from the control FSM, and produces the 64-bit HI/LO result pair. It executes MULT, MULTU, DIV and DIVU over a fixed number of cycles with a start/busy/done handshake. HI and LO are read back through the register-write mux (MFHI/MFLO) and written directly by MTHI/MTLO.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- Clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- opA  in  WIDTH  multiplicand / dividend (A register).
- opB  in  WIDTH  multiplier / divisor (B register).
- hi_load  in  1  MTHI: write `wdata` to HI.
- lo_load  in  1  MTLO: write `wdata` to LO.
- wdata  in  WIDTH  data for MTHI/MTLO.
- HI  out  WIDTH  high product / remainder; reset 0.
- LO  out  WIDTH  low product / quotient; reset 0.
- busy  out  1  high in CALC and FIX; reset 0.
- done  out  1  one-cycle completion pulse; reset 0.
- div_zero  out  1  one-cycle pulse, coincident with done, when a divide has opB = 0; reset 0.
- illegal  out  1  one-cycle pulse for a divide op when the divider is compiled out; reset 0.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start = 1, normal case: latch operand magnitudes, sign flags, op; counter = 0; go to CALC.
  - Magnitudes are two's-complement absolute values for signed ops, raw values for unsigned ops.
- IDLE, start = 1, divide op with opB = 0: go directly to DONE.
  - HI and LO stay unchanged.
  - done and div_zero assert together.
- CALC, multiply: one shift-add iteration per cycle on the 64-bit {acc, multiplier} pair.
- CALC, divide: one restoring-division iteration per cycle. Shift the remainder left, subtract the divisor, and keep the result if it is non-negative; the quotient bit is the inverted borrow.
- CALC runs WIDTH iterations, counter 0..WIDTH-1, then goes to FIX.
- FIX, signed ops:
  - MULT: product negated if signA ^ signB.
  - DIV: quotient negated if signA ^ signB; remainder negated if signA.
- FIX, all ops: write HI/LO, go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Arithmetic rules:
  - All arithmetic is modulo 2^WIDTH per half.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0; no flag.
- start while busy or in DONE is ignored.
- hi_load/lo_load:
  - In IDLE: take effect at the next edge.
  - In any other state: dropped.
  - Same cycle as start in IDLE: the load applies, and the computed result later overwrites it.
- Invalid op encodings cannot occur, since op is 2 bits.

## Timing
- Start sampled at edge E0; busy = 1 from E0 until E32.
- HI/LO updated at edge E(WIDTH+1) = E33.
- done high during the cycle after E33, i.e. 34 cycles from E0 to the done falling edge.
- Divide-by-zero: done/div_zero high in the cycle after E0. HI/LO unchanged.
- HI/LO keep their last value in every other state and are not disturbed during CALC; internal accumulators are separate.
- Reset asserted mid-operation, asynchronously:
  - state = IDLE; HI = LO = 0; busy = done = div_zero = illegal = 0.
  - No partial result is visible.
- New start accepted in the cycle after done, i.e. IDLE.

## Configuration
- MULT_DIV_DIVIDER_EN
  - Defined: divider datapath and DIV/DIVU behaviour as above.
  - Undefined: divider logic is removed. A DIV/DIVU start goes IDLE → DONE in one cycle with done = illegal = 1 and HI/LO unchanged, so control raises the invalid-code exception. Multiply behaviour is identical in both builds.

## Test plan
- MULT opA = 0xFFFFFFFD (−3), opB = 5 → at E33 HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; done one cycle; busy high for E0..E32.
- MULTU opA = opB = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV opA = 0xFFFFFFF9 (−7), opB = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU opA = 100, opB = 7 → LO = 14, HI = 2.
- After MTHI 0x1234 and MTLO 0x5678, issue DIVU opA = 100, opB = 0 → the next cycle has done = div_zero = 1; HI = 0x1234, LO = 0x5678 retained.
- Start MULT 6×7, pulse start again at E10, and assert reset at E20 → the second start is ignored; after reset HI = LO = 0 and busy = done = 0. A new MULT 6×7 then gives LO = 42, HI = 0 at E33.
- Build without MULT_DIV_DIVIDER_EN and issue DIV 10/3 → done = illegal = 1 in the next cycle; HI/LO unchanged; MULT 6×7 still gives LO = 42.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential MULT/MULTU/DIV/DIVU unit with HI/LO; divider built only with MULT_DIV_DIVIDER_EN
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             hi_load,
  input  logic             lo_load,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] acc, shf, m, mag_a, mag_b;
  logic [CW-1:0] cnt;
  logic sign_a, sign_b, a_neg, b_neg;
  logic [WIDTH:0] madd;
  logic [2*WIDTH-1:0] prod;
  assign a_neg = ~op[0] & opA[WIDTH-1];
  assign b_neg = ~op[0] & opB[WIDTH-1];
  assign mag_a = a_neg ? -opA : opA;
  assign mag_b = b_neg ? -opB : opB;
  assign madd = shf[0] ? {1'b0, acc} + {1'b0, m} : {1'b0, acc};
  assign prod = (sign_a ^ sign_b) ? -{acc, shf} : {acc, shf};
`ifdef MULT_DIV_DIVIDER_EN
  logic is_div, borrow;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH-1:0] diff, quo, rem;
  assign rem_sh = {acc, shf[WIDTH-1]};
  assign borrow = rem_sh < {1'b0, m};
  assign diff = rem_sh[WIDTH-1:0] - m;
  assign quo = (sign_a ^ sign_b) ? -shf : shf;
  assign rem = sign_a ? -acc : acc;
`endif
  // control FSM, iterative datapath and registered HI/LO/status outputs
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      HI <= '0;
      LO <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
      illegal <= 1'b0;
      acc <= '0;
      shf <= '0;
      m <= '0;
      cnt <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
`ifdef MULT_DIV_DIVIDER_EN
      is_div <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      div_zero <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_load) HI <= wdata;
          if (lo_load) LO <= wdata;
          if (start) begin
`ifdef MULT_DIV_DIVIDER_EN
            if (op[1] && opB == '0) begin
              state <= DONE;
              done <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= CALC;
              busy <= 1'b1;
              cnt <= '0;
              is_div <= op[1];
              sign_a <= a_neg;
              sign_b <= b_neg;
              acc <= '0;
              shf <= op[1] ? mag_a : mag_b;
              m <= op[1] ? mag_b : mag_a;
            end
`else
            if (op[1]) begin
              state <= DONE;
              done <= 1'b1;
              illegal <= 1'b1;
            end else begin
              state <= CALC;
              busy <= 1'b1;
              cnt <= '0;
              sign_a <= a_neg;
              sign_b <= b_neg;
              acc <= '0;
              shf <= mag_b;
              m <= mag_a;
            end
`endif
          end
        end
        CALC: begin
`ifdef MULT_DIV_DIVIDER_EN
          if (is_div) begin
            acc <= borrow ? rem_sh[WIDTH-1:0] : diff;
            shf <= {shf[WIDTH-2:0], ~borrow};
          end else begin
            acc <= madd[WIDTH:1];
            shf <= {madd[0], shf[WIDTH-1:1]};
          end
`else
          acc <= madd[WIDTH:1];
          shf <= {madd[0], shf[WIDTH-1:1]};
`endif
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
`ifdef MULT_DIV_DIVIDER_EN
          if (is_div) begin
            HI <= rem;
            LO <= quo;
          end else
`endif
          {HI, LO} <= prod;
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized scoreboard bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
  localparam int W = 32;
`ifdef MULT_DIV_DIVIDER_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic Clk = 1'b0, reset = 1'b1, start = 1'b0, hi_load = 1'b0, lo_load = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] opA = '0, opB = '0, wdata = '0;
  logic [W-1:0] HI, LO;
  logic busy, done, div_zero, illegal;
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic dz;
    logic ill;
    int dcyc;
    int bcnt;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0, cyc = 0, bcnt = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .hi_load(hi_load), .lo_load(lo_load), .wdata(wdata),
    .HI(HI), .LO(LO), .busy(busy), .done(done), .div_zero(div_zero), .illegal(illegal)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'd1;
      4: v = W'($urandom_range(0, 20));
      5: v = -W'($urandom_range(1, 20));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // issue one operation at an IDLE negedge, push its expected response, pace until done
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic hl, input logic ll, input logic [W-1:0] wd);
    exp_t e;
    logic [63:0] p;
    longint sa, sb;
    bit got;
    start = 1'b1; op = o; opA = a; opB = b; hi_load = hl; lo_load = ll; wdata = wd;
    if (hl) m_hi = wd;
    if (ll) m_lo = wd;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0; e.ill = 1'b0; e.dcyc = cyc + 1; e.bcnt = 0;
    if (o[1] && !DIV_EN) e.ill = 1'b1;
    else if (o[1] && b == '0) e.dz = 1'b1;
    else begin
      case (o)
        2'b00: p = 64'(sa * sb);
        2'b01: p = {32'b0, a} * {32'b0, b};
        2'b10: p = {32'(sa % sb), 32'(sa / sb)};
        default: p = {a % b, a / b};
      endcase
      {m_hi, m_lo} = p;
      e.dcyc = cyc + 34;
      e.bcnt = 33;
    end
    e.hi = m_hi;
    e.lo = m_lo;
    q.push_back(e);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge Clk);
      start = 1'($urandom); hi_load = 1'($urandom); lo_load = 1'($urandom);
      op = 2'($urandom); opA = W'($urandom); opB = W'($urandom); wdata = W'($urandom);
      if (done) got = 1;
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
    @(negedge Clk);
    start = 1'b0; hi_load = 1'b0; lo_load = 1'b0;
  endtask

  task automatic load(input logic hl, input logic ll, input logic [W-1:0] wd);
    hi_load = hl; lo_load = ll; wdata = wd;
    if (hl) m_hi = wd;
    if (ll) m_lo = wd;
    @(negedge Clk);
    hi_load = 1'b0; lo_load = 1'b0;
  endtask

  // monitor: pops the scoreboard whenever the DUT signals completion
  always @(negedge Clk) begin : mon
    exp_t e;
    if (reset) bcnt = 0;
    else begin
      if (busy) bcnt++;
      if (!done) chk("stray_flag", {62'b0, div_zero, illegal}, 64'd0);
      else if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("hi", HI, e.hi);
        chk("lo", LO, e.lo);
        chk("div_zero", div_zero, e.dz);
        chk("illegal", illegal, e.ill);
        chk("done_cycle", cyc, e.dcyc);
        chk("busy_cycles", bcnt, e.bcnt);
        chk("busy_at_done", busy, 1'b0);
        bcnt = 0;
      end
    end
  end

  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_illegal", illegal, 0);
    reset = 1'b0;
    @(negedge Clk);
    issue(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    issue(2'b11, 32'd100, 32'd7, 0, 0, 0);
    load(1, 0, 32'h1234);
    load(0, 1, 32'h5678);
    issue(2'b11, 32'd100, 32'd0, 0, 0, 0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    issue(2'b10, 32'd10, 32'd3, 0, 0, 0);
    issue(2'b00, 32'd6, 32'd7, 0, 0, 0);
    // aborted MULT with a second start mid-flight, then asynchronous reset
    start = 1'b1; op = 2'b00; opA = 32'd6; opB = 32'd7;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      start = (i == 10);
      op = 2'b01; opA = 32'hFFFF_FFFF; opB = 32'hFFFF_FFFF;
      if (i == 19) begin
        chk("mid_busy", busy, 1);
        chk("mid_hi_undisturbed", HI, m_hi);
        chk("mid_lo_undisturbed", LO, m_lo);
      end
    end
    #2 reset = 1'b1;
    #1;
    chk("async_rst_hi", HI, 0);
    chk("async_rst_lo", LO, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    q.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge Clk);
    #2 reset = 1'b0;
    @(negedge Clk);
    issue(2'b00, 32'd6, 32'd7, 0, 0, 0);
    issue(2'b01, 32'd3, 32'd4, 1, 1, 32'hDEAD_BEEF);
    issue(2'b11, 32'd9, 32'd0, 1, 0, 32'hCAFE_F00D);
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] a, b;
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? '0 : pick();
      issue(2'($urandom_range(0, 3)), a, b, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), W'($urandom));
    end
    repeat (3) @(negedge Clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
